// File: rtl/i2s_frame_capture_if.sv
// Stereo sample stream from the I2S frame capture block toward the DAC/modulator path.
// The capture block drives the master side; the consumer drives sample_ready.
interface i2s_frame_capture_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic                    sample_valid;
    logic                    sample_ready;
    logic [SAMPLE_WIDTH-1:0] sample_left;
    logic [SAMPLE_WIDTH-1:0] sample_right;

    modport master (
        output sample_valid,
        output sample_left,
        output sample_right,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_left,
        input  sample_right,
        output sample_ready
    );
endinterface

// File: rtl/i2s_frame_capture.sv
// Captures left/right words at word-select boundaries, checks word length,
// truncates to the sample width and queues stereo pairs in a small FIFO.
module i2s_frame_capture #(
    parameter int DATA_SIZE    = 32,
    parameter int SAMPLE_WIDTH = 24,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          sck_clk,
    input  logic                          rst,
    input  logic                          ws_in,
    input  logic [DATA_SIZE-1:0]          left_in,
    input  logic [DATA_SIZE-1:0]          right_in,
    input  logic                          clear_flags,
    i2s_frame_capture_if.master           sample_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err
);
    localparam int CW = $clog2(DATA_SIZE) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] CNT_WORD   = CW'(DATA_SIZE);
    localparam logic [PW:0]   LEVEL_FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t                  state_q, state_d;
    logic                    ws_q, ws_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                    left_ok_q, left_ok_d;
    logic [SAMPLE_WIDTH-1:0] mem_left_q  [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_left_d  [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_right_q [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_right_d [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW:0]             level_q, level_d;
    logic                    overflow_q, overflow_d;
    logic                    frame_err_q, frame_err_d;

    logic rise, fall, word_ok, push_req, push_ok, pop, set_fe, set_ov;

    always_comb begin
        state_d     = state_q;
        ws_d        = ws_in;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        mem_left_d  = mem_left_q;
        mem_right_d = mem_right_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        push_req    = 1'b0;
        set_fe      = 1'b0;

        rise    = ws_in & ~ws_q;
        fall    = ~ws_in & ws_q;
        word_ok = (bit_cnt_q == CNT_WORD);

        if (rise || fall)
            bit_cnt_d = CW'(1);
        else if (bit_cnt_q == CNT_MAX)
            bit_cnt_d = bit_cnt_q;
        else
            bit_cnt_d = bit_cnt_q + CW'(1);

        // A pair is only judged once both words have been bounded by edges seen after sync.
        unique case (state_q)
            SYNC: begin
                if (rise)
                    state_d = LEFT;
            end
            LEFT: begin
                if (fall) begin
                    left_hold_d = left_in[DATA_SIZE-1 -: SAMPLE_WIDTH];
                    left_ok_d   = word_ok;
                    state_d     = RIGHT;
                end
            end
            RIGHT: begin
                if (rise) begin
                    state_d = LEFT;
                    if (left_ok_q && word_ok)
                        push_req = 1'b1;
                    else
                        set_fe = 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase

        pop     = (level_q != '0) && sample_if.sample_ready;
        push_ok = push_req && ((level_q != LEVEL_FULL) || pop);
        set_ov  = push_req && !push_ok;

        if (push_ok) begin
            mem_left_d[wr_ptr_q]  = left_hold_q;
            mem_right_d[wr_ptr_q] = right_in[DATA_SIZE-1 -: SAMPLE_WIDTH];
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);

        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + (PW+1)'(1);
            2'b01:   level_d = level_q - (PW+1)'(1);
            default: level_d = level_q;
        endcase

        overflow_d  = set_ov ? 1'b1 : (clear_flags ? 1'b0 : overflow_q);
        frame_err_d = set_fe ? 1'b1 : (clear_flags ? 1'b0 : frame_err_q);
    end

    always_ff @(posedge sck_clk) begin
        if (rst) begin
            state_q     <= SYNC;
            ws_q        <= 1'b0;
            bit_cnt_q   <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            mem_left_q  <= '{default: '0};
            mem_right_q <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ws_q        <= ws_d;
            bit_cnt_q   <= bit_cnt_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            mem_left_q  <= mem_left_d;
            mem_right_q <= mem_right_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign sample_if.sample_valid = (level_q != '0);
    assign sample_if.sample_left  = mem_left_q[rd_ptr_q];
    assign sample_if.sample_right = mem_right_q[rd_ptr_q];
    assign fifo_level             = level_q;
    assign overflow               = overflow_q;
    assign frame_err              = frame_err_q;

    // Truncated LSBs of the receiver words are intentionally discarded.
    if (SAMPLE_WIDTH < DATA_SIZE) begin : g_trunc
        logic unused_low_bits;
        assign unused_low_bits = ^{left_in[DATA_SIZE-SAMPLE_WIDTH-1:0],
                                   right_in[DATA_SIZE-SAMPLE_WIDTH-1:0]};
    end
endmodule

// File: tb/tb_i2s_frame_capture.sv
// Self-checking bench: directed frame scenarios plus randomized frames, compared
// cycle by cycle against a queue-based reference of the capture rules.
module tb_i2s_frame_capture;
    localparam int DATA_SIZE    = 32;
    localparam int SAMPLE_WIDTH = 24;
    localparam int FIFO_DEPTH   = 4;

    logic                 sck_clk = 1'b0;
    logic                 rst;
    logic                 ws_in;
    logic [DATA_SIZE-1:0] left_in;
    logic [DATA_SIZE-1:0] right_in;
    logic                 clear_flags;
    logic [2:0]           fifo_level;
    logic                 overflow;
    logic                 frame_err;

    i2s_frame_capture_if #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) sample_if ();

    i2s_frame_capture #(
        .DATA_SIZE   (DATA_SIZE),
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .sck_clk    (sck_clk),
        .rst        (rst),
        .ws_in      (ws_in),
        .left_in    (left_in),
        .right_in   (right_in),
        .clear_flags(clear_flags),
        .sample_if  (sample_if),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 sck_clk = ~sck_clk;

    typedef struct {
        logic [SAMPLE_WIDTH-1:0] l;
        logic [SAMPLE_WIDTH-1:0] r;
    } pair_t;

    pair_t                   ref_q[$];
    int                      ref_phase;
    logic                    ref_ws_prev;
    int                      ref_run;
    logic [SAMPLE_WIDTH-1:0] ref_pend_left;
    bit                      ref_pend_ok;
    bit                      ref_ov;
    bit                      ref_fe;
    int                      ready_mode;
    int                      tests_run    = 0;
    int                      tests_failed = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Phase 0 waits for the first rise, 1 expects the end of a left word, 2 of a right word.
    task automatic refModelStep();
        bit pop, push, set_ov, set_fe, word_ok;
        if (rst) begin
            ref_q.delete();
            ref_phase   = 0;
            ref_ws_prev = 1'b0;
            ref_run     = 0;
            ref_pend_ok = 1'b0;
            ref_ov      = 1'b0;
            ref_fe      = 1'b0;
            return;
        end
        pop     = (ref_q.size() != 0) && sample_if.sample_ready;
        push    = 1'b0;
        set_ov  = 1'b0;
        set_fe  = 1'b0;
        word_ok = (ref_run == DATA_SIZE);
        if (ref_phase == 0 && ws_in && !ref_ws_prev) begin
            ref_phase = 1;
        end else if (ref_phase == 1 && !ws_in && ref_ws_prev) begin
            ref_pend_left = left_in[DATA_SIZE-1 -: SAMPLE_WIDTH];
            ref_pend_ok   = word_ok;
            ref_phase     = 2;
        end else if (ref_phase == 2 && ws_in && !ref_ws_prev) begin
            if (ref_pend_ok && word_ok) push = 1'b1;
            else                        set_fe = 1'b1;
            ref_phase = 1;
        end
        if (pop) void'(ref_q.pop_front());
        if (push) begin
            if (ref_q.size() < FIFO_DEPTH)
                ref_q.push_back('{l: ref_pend_left, r: right_in[DATA_SIZE-1 -: SAMPLE_WIDTH]});
            else
                set_ov = 1'b1;
        end
        if (clear_flags) begin
            ref_ov = 1'b0;
            ref_fe = 1'b0;
        end
        if (set_ov) ref_ov = 1'b1;
        if (set_fe) ref_fe = 1'b1;
        ref_run     = (ws_in != ref_ws_prev) ? 1 : ref_run + 1;
        ref_ws_prev = ws_in;
    endtask

    task automatic applyStimulus(input logic ws, input int ready_override);
        ws_in = ws;
        if (ready_override >= 0)  sample_if.sample_ready = ready_override[0];
        else if (ready_mode == 2) sample_if.sample_ready = 1'($urandom_range(0, 1));
        else                      sample_if.sample_ready = ready_mode[0];
        refModelStep();
        @(posedge sck_clk);
        #1;
        checkOutput("valid", 64'(sample_if.sample_valid), 64'(ref_q.size() != 0));
        checkOutput("level", 64'(fifo_level), 64'(ref_q.size()));
        checkOutput("overflow", 64'(overflow), 64'(ref_ov));
        checkOutput("frame_err", 64'(frame_err), 64'(ref_fe));
        if (ref_q.size() != 0) begin
            checkOutput("left", 64'(sample_if.sample_left), 64'(ref_q[0].l));
            checkOutput("right", 64'(sample_if.sample_right), 64'(ref_q[0].r));
        end
        clear_flags = 1'b0;
    endtask

    task automatic sendFrame(input logic [DATA_SIZE-1:0] l, input logic [DATA_SIZE-1:0] r,
                             input int llen, input int rlen, input int first_ready);
        for (int i = 0; i < llen; i++) begin
            if (i == 1) begin
                left_in  = l;
                right_in = r;
            end
            applyStimulus(1'b1, (i == 0) ? first_ready : -1);
        end
        for (int i = 0; i < rlen; i++) applyStimulus(1'b0, -1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 0);
        checkOutput("rst_left", 64'(sample_if.sample_left), 64'h0);
        checkOutput("rst_right", 64'(sample_if.sample_right), 64'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst                    = 1'b1;
        ws_in                  = 1'b0;
        left_in                = '0;
        right_in               = '0;
        clear_flags            = 1'b0;
        sample_if.sample_ready = 1'b0;
        ready_mode             = 0;

        // Well-formed frames drained continuously.
        doReset();
        ready_mode = 1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, -1);
        for (int i = 0; i < 3; i++) sendFrame(32'h12345678, 32'h9ABCDEF0, 32, 32, -1);
        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -1);

        // Fill past depth with the consumer stalled, then drain.
        ready_mode = 0;
        for (int i = 0; i < 31; i++) applyStimulus(1'b1, -1);
        for (int i = 0; i < 32; i++) applyStimulus(1'b0, -1);
        for (int f = 0; f < 6; f++) sendFrame($urandom, $urandom, 32, 32, -1);
        ready_mode = 1;
        sendFrame($urandom, $urandom, 32, 32, -1);

        // Short left word followed by a good frame, then clear.
        sendFrame(32'hCAFEBABE, 32'h0BADF00D, 31, 32, -1);
        sendFrame(32'hA5A5A5A5, 32'h5A5A5A5A, 32, 32, -1);
        sendFrame(32'h11112222, 32'h33334444, 32, 32, -1);
        clear_flags = 1'b1;
        applyStimulus(1'b1, -1);

        // Full FIFO with a pop on the same rise-edge cycle as a push.
        doReset();
        ready_mode = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, -1);
        for (int f = 0; f < 5; f++) sendFrame($urandom, $urandom, 32, 32, -1);
        sendFrame($urandom, $urandom, 32, 32, 1);
        ready_mode = 1;
        sendFrame($urandom, $urandom, 32, 32, -1);

        // Reset in the middle of a right word with pairs queued.
        ready_mode = 0;
        for (int f = 0; f < 2; f++) sendFrame($urandom, $urandom, 32, 32, -1);
        sendFrame($urandom, $urandom, 32, 10, -1);
        doReset();
        for (int i = 0; i < 22; i++) applyStimulus(1'b0, -1);
        ready_mode = 1;
        for (int f = 0; f < 3; f++) sendFrame($urandom, $urandom, 32, 32, -1);

        // Word select stuck low long enough to saturate the length counter.
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, -1);
        sendFrame($urandom, $urandom, 32, 32, -1);
        sendFrame($urandom, $urandom, 32, 32, -1);
        clear_flags = 1'b1;
        applyStimulus(1'b1, -1);
        for (int i = 0; i < 31; i++) applyStimulus(1'b1, -1);
        for (int i = 0; i < 32; i++) applyStimulus(1'b0, -1);

        // Randomized frames, lengths, back-pressure and flag clears.
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            int llen, rlen;
            llen = ($urandom_range(0, 4) == 0) ? int'($urandom_range(29, 35)) : 32;
            rlen = ($urandom_range(0, 4) == 0) ? int'($urandom_range(29, 35)) : 32;
            clear_flags = ($urandom_range(0, 9) == 0);
            sendFrame($urandom, $urandom, llen, rlen, -1);
        end
        applyStimulus(1'b1, -1);
        ready_mode = 1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
